// File: rtl/firc_pkg.sv
// Shared types and widths for the complex FIR datapath and its input buffer.
package firc_pkg;

  localparam int SAMP_W     = 24;
  localparam int COEF_W     = 27;
  localparam int OUT_W      = 32;
  localparam int NTAPS_HALF = 15;

  typedef struct packed {
    logic [SAMP_W-1:0] i;
    logic [SAMP_W-1:0] q;
  } samp_t;

endpackage

// File: rtl/firc_fifo_mem.sv
// Register-array storage for the FIR input FIFO: one write port and one
// asynchronous read port, cleared on reset.
module firc_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 48,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  // NOTE: the whole array is copied before the conditional write so every
  // element has a value on every path and no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // NOTE: storage is reset on purpose so the head output reads 0 after reset;
  // state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/firc_in_fifo.sv
// Input sample FIFO ahead of the complex FIR: Push/Stop handshake on both
// sides, registered occupancy count and a sticky overflow flag.
module firc_in_fifo
  import firc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SW    = SAMP_W,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          PushIn,
  output logic          StopIn,
  input  logic [SW-1:0] SampIIn,
  input  logic [SW-1:0] SampQIn,
  output logic          PushOut,
  input  logic          StopOut,
  output logic [SW-1:0] SampIOut,
  output logic [SW-1:0] SampQOut,
  output logic [CW-1:0] Count,
  output logic          Overflow
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            overflow_q, overflow_d;
  logic            wr_en, rd_en;
  logic [2*SW-1:0] rd_data;

  // Handshake outputs depend on the registered count only.
  assign StopIn  = (count_q == FULL_CNT);
  assign PushOut = (count_q != '0);
  assign wr_en   = PushIn && !StopIn;
  assign rd_en   = PushOut && !StopOut;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (PushIn & StopIn);
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  firc_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (2 * SW),
    .AW    (PW)
  ) u_mem (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({SampIIn, SampQIn}),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign {SampIOut, SampQOut} = rd_data;
  assign Count                = count_q;
  assign Overflow             = overflow_q;

endmodule
